rv32i_lsu_wb: RTL and testbench

Load/store unit bridging the RV32I core's memory stage to the Wishbone data port that the data memory serves. It accepts one load or store at a time from the pipeline and checks alignment. It builds word-aligned Wishbone cycles with byte selects and replicated store data, then returns sign- or zero-extended load data, or an error or misalign flag, to writeback. Sits directly upstream of the data memory on the Wishbone bus.

---
 rtl/rv32i_lsu_pkg.sv | 38 +++
 rtl/rv32i_wb_pkg.sv | 6 +
 rtl/rv32i_lsu_align.sv | 51 +++++
 rtl/rv32i_lsu_wb.sv | 188 ++++++++++++++++++
 tb/tb_rv32i_lsu_wb.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_lsu_pkg.sv
// Load/store unit operation encoding and helpers.
package rv32i_lsu_pkg;
    typedef enum logic [2:0] {
        LSU_LB  = 3'd0,
        LSU_LH  = 3'd1,
        LSU_LW  = 3'd2,
        LSU_LBU = 3'd3,
        LSU_LHU = 3'd4,
        LSU_SB  = 3'd5,
        LSU_SH  = 3'd6,
        LSU_SW  = 3'd7
    } lsu_op_e;

    function automatic logic is_store(input lsu_op_e op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    // 0 = byte, 1 = halfword, 2 = word
    function automatic logic [1:0] op_size(input lsu_op_e op);
        logic [1:0] size;
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: size = 2'd0;
            LSU_LH, LSU_LHU, LSU_SH: size = 2'd1;
            default:                 size = 2'd2;
        endcase
        return size;
    endfunction

    function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] off);
        logic mis;
        case (op_size(op))
            2'd0:    mis = 1'b0;
            2'd1:    mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction
endpackage

// File: rtl/rv32i_wb_pkg.sv
// Wishbone data-port geometry shared by the RV32I core and its data memory.
package rv32i_wb_pkg;
    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_ADDR_WIDTH = 32;
    localparam int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8;
endpackage

// File: rtl/rv32i_lsu_align.sv
// Combinational lane logic: store replication/byte selects and load extraction/extension.
module rv32i_lsu_align
    import rv32i_lsu_pkg::*;
    import rv32i_wb_pkg::*;
(
    input  lsu_op_e                  st_op_i,
    input  logic [1:0]               st_off_i,
    input  logic [31:0]              st_wdata_i,
    output logic [WB_SEL_WIDTH-1:0]  st_sel_o,
    output logic [WB_DATA_WIDTH-1:0] st_dat_o,
    input  lsu_op_e                  ld_op_i,
    input  logic [1:0]               ld_off_i,
    input  logic [WB_DATA_WIDTH-1:0] ld_word_i,
    output logic [31:0]              ld_rdata_o
);
    logic [31:0] lane_s;

    // Selects and replicated store data; loads reuse the same select pattern.
    always_comb begin
        st_sel_o = 4'h0;
        st_dat_o = 32'h0;
        case (op_size(st_op_i))
            2'd0: begin
                st_sel_o = 4'b0001 << st_off_i;
                st_dat_o = {4{st_wdata_i[7:0]}};
            end
            2'd1: begin
                st_sel_o = 4'b0011 << st_off_i;
                st_dat_o = {2{st_wdata_i[15:0]}};
            end
            default: begin
                st_sel_o = 4'hF;
                st_dat_o = st_wdata_i;
            end
        endcase
    end

    assign lane_s = ld_word_i >> {ld_off_i, 3'b000};

    // Pick the addressed lane and extend it to 32 bits.
    always_comb begin
        ld_rdata_o = 32'h0;
        case (ld_op_i)
            LSU_LB:  ld_rdata_o = {{24{lane_s[7]}}, lane_s[7:0]};
            LSU_LH:  ld_rdata_o = {{16{lane_s[15]}}, lane_s[15:0]};
            LSU_LBU: ld_rdata_o = {24'h0, lane_s[7:0]};
            LSU_LHU: ld_rdata_o = {16'h0, lane_s[15:0]};
            default: ld_rdata_o = ld_word_i;
        endcase
    end
endmodule

// File: rtl/rv32i_lsu_wb.sv
// Single-outstanding load/store unit driving a Wishbone data port.
// Define RV32I_LSU_TIMEOUT_EN to abort bus cycles after TIMEOUT_CYCLES with an error.
module rv32i_lsu_wb
    import rv32i_lsu_pkg::*;
    import rv32i_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  lsu_op_e                  req_op_i,
    input  logic [31:0]              req_addr_i,
    input  logic [31:0]              req_wdata_i,
    output logic                     rsp_valid_o,
    output logic [31:0]              rsp_rdata_o,
    output logic                     rsp_err_o,
    output logic                     rsp_misalign_o,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    output logic                     wb_we_o,
    output logic [WB_SEL_WIDTH-1:0]  wb_sel_o,
    output logic [WB_ADDR_WIDTH-1:0] wb_adr_o,
    output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
    input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
    input  logic                     wb_ack_i,
    input  logic                     wb_err_i,
    input  logic                     wb_stall_i
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_e;

    state_e                   state_q, state_d;
    lsu_op_e                  op_q, op_d;
    logic [1:0]               off_q, off_d;
    logic                     ready_q, ready_d;
    logic                     cyc_q, cyc_d, we_q, we_d;
    logic [WB_SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
    logic                     rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic                     rsp_mis_q, rsp_mis_d;
    logic [31:0]              rsp_rdata_q, rsp_rdata_d;
    logic [WB_SEL_WIDTH-1:0]  st_sel_s;
    logic [WB_DATA_WIDTH-1:0] st_dat_s;
    logic [31:0]              ld_rdata_s;
    logic                     timeout_s;
    logic                     stall_unused_s;

    // Stall only delays the slave; stb is simply held, so the input carries no information here.
    assign stall_unused_s = wb_stall_i;

    rv32i_lsu_align u_align (
        .st_op_i    (req_op_i),
        .st_off_i   (req_addr_i[1:0]),
        .st_wdata_i (req_wdata_i),
        .st_sel_o   (st_sel_s),
        .st_dat_o   (st_dat_s),
        .ld_op_i    (op_q),
        .ld_off_i   (off_q),
        .ld_word_i  (wb_dat_i),
        .ld_rdata_o (ld_rdata_s)
    );

`ifdef RV32I_LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q;

    // Counts BUS cycles; held at zero outside BUS so each bus cycle starts fresh.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else if (state_q == BUS) begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    assign timeout_s = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and registered-output logic; bus fields are frozen while in BUS.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_mis_d   = 1'b0;
        rsp_rdata_d = 32'h0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    op_d  = req_op_i;
                    off_d = req_addr_i[1:0];
                    if (is_misaligned(req_op_i, req_addr_i[1:0])) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_mis_d   = 1'b1;
                    end else begin
                        state_d = BUS;
                        cyc_d   = 1'b1;
                        we_d    = is_store(req_op_i);
                        sel_d   = st_sel_s;
                        adr_d   = {req_addr_i[31:2], 2'b00};
                        dat_d   = is_store(req_op_i) ? st_dat_s : {WB_DATA_WIDTH{1'b0}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                if (wb_err_i || wb_ack_i || timeout_s) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    sel_d       = {WB_SEL_WIDTH{1'b0}};
                    adr_d       = {WB_ADDR_WIDTH{1'b0}};
                    dat_d       = {WB_DATA_WIDTH{1'b0}};
                    if (wb_err_i || !wb_ack_i) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        rsp_rdata_d = is_store(op_q) ? 32'h0 : ld_rdata_s;
                    end
                end else begin
                    state_d = BUS;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            op_q        <= LSU_LW;
            off_q       <= 2'b00;
            ready_q     <= 1'b1;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= {WB_SEL_WIDTH{1'b0}};
            adr_q       <= {WB_ADDR_WIDTH{1'b0}};
            dat_q       <= {WB_DATA_WIDTH{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_mis_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            ready_q     <= ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_mis_q   <= rsp_mis_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready_o    = ready_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_rdata_o    = rsp_rdata_q;
    assign rsp_err_o      = rsp_err_q;
    assign rsp_misalign_o = rsp_mis_q;
    assign wb_cyc_o       = cyc_q;
    assign wb_stb_o       = cyc_q;
    assign wb_we_o        = we_q;
    assign wb_sel_o       = sel_q;
    assign wb_adr_o       = adr_q;
    assign wb_dat_o       = dat_q;
endmodule

// File: tb/tb_rv32i_lsu_wb.sv
// Directed bench for rv32i_lsu_wb against a small Wishbone data-memory model.
module tb_rv32i_lsu_wb;
    import rv32i_lsu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    lsu_op_e     req_op_i = LSU_LW;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic        rsp_valid_o, rsp_err_o, rsp_misalign_o;
    logic [31:0] rsp_rdata_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_stall_i = 1'b0;

    int total = 0;
    int fails = 0;

    // slave controls
    int   wait_n = 0;
    int   wcnt = 0;
    bit   inj_err = 1'b0;
    bit   no_ack = 1'b0;
    logic [31:0] mem [256];

    // results of the last request
    int          r_lat, r_ack_lat;
    logic [31:0] r_rdata, f_adr, f_sel, f_dat;
    logic        r_err, r_mis, r_cyc_seen, r_unstable, f_we, r_extra;

    rv32i_lsu_wb #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_misalign_o(rsp_misalign_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_stall_i(wb_stall_i)
    );

    always #5 clk_i = ~clk_i;

    // Data memory with registered ack after wait_n wait cycles.
    always @(posedge clk_i) begin
        wb_ack_i <= 1'b0;
        wb_err_i <= 1'b0;
        if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i) begin
            if (wcnt >= wait_n && !no_ack) begin
                wb_ack_i   <= 1'b1;
                wb_err_i   <= inj_err;
                wb_stall_i <= 1'b0;
                wcnt       <= 0;
                wb_dat_i   <= mem[wb_adr_o[9:2]];
                if (wb_we_o) begin
                    for (int i = 0; i < 4; i++)
                        if (wb_sel_o[i]) mem[wb_adr_o[9:2]][8*i +: 8] <= wb_dat_o[8*i +: 8];
                end
            end else begin
                wcnt       <= wcnt + 1;
                wb_stall_i <= (wait_n > 0);
            end
        end else if (!wb_cyc_o) begin
            wcnt       <= 0;
            wb_stall_i <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request; latency counts cycles after the accept edge (cyc appears at 1).
    task automatic run(input lsu_op_e op, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        r_lat = 1; r_ack_lat = -1; r_cyc_seen = 1'b0; r_unstable = 1'b0;
        r_rdata = 32'hX; r_err = 1'bX; r_mis = 1'bX;
        while (!rsp_valid_o && r_lat < 60) begin
            if (wb_cyc_o) begin
                if (!r_cyc_seen) begin
                    f_adr = wb_adr_o; f_sel = {28'h0, wb_sel_o}; f_dat = wb_dat_o; f_we = wb_we_o;
                end else if (wb_adr_o !== f_adr || {28'h0, wb_sel_o} !== f_sel ||
                             wb_dat_o !== f_dat || wb_we_o !== f_we) begin
                    r_unstable = 1'b1;
                end
                if (wb_stb_o !== 1'b1) r_unstable = 1'b1;
                r_cyc_seen = 1'b1;
            end
            if (wb_ack_i && r_ack_lat < 0) r_ack_lat = r_lat;
            @(posedge clk_i);
            #1;
            r_lat++;
        end
        if (rsp_valid_o) begin
            r_rdata = rsp_rdata_o; r_err = rsp_err_o; r_mis = rsp_misalign_o;
            if (wb_cyc_o) r_cyc_seen = 1'b1;
        end else begin
            r_lat = -1;
        end
        @(posedge clk_i);
        #1;
        r_extra = rsp_valid_o;
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        // reset state
        #12;
        chk("rst_ready", {31'h0, req_ready_o}, 32'h1);
        chk("rst_cyc",   {31'h0, wb_cyc_o}, 32'h0);
        chk("rst_stb",   {31'h0, wb_stb_o}, 32'h0);
        chk("rst_rspv",  {31'h0, rsp_valid_o}, 32'h0);
        chk("rst_sel",   {28'h0, wb_sel_o}, 32'h0);
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);

        // SW word store, zero-wait
        run(LSU_SW, 32'h100, 32'hDEADBEEF);
        chk("sw_lat",   r_lat, 32'd3);
        chk("sw_sel",   f_sel, 32'hF);
        chk("sw_adr",   f_adr, 32'h100);
        chk("sw_dat",   f_dat, 32'hDEADBEEF);
        chk("sw_we",    {31'h0, f_we}, 32'h1);
        chk("sw_err",   {31'h0, r_err}, 32'h0);
        chk("sw_rdata", r_rdata, 32'h0);
        chk("sw_single", {31'h0, r_extra}, 32'h0);

        run(LSU_LW, 32'h100, 32'h0);
        chk("lw_rdata", r_rdata, 32'hDEADBEEF);
        chk("lw_we",    {31'h0, f_we}, 32'h0);
        chk("lw_dat_o", f_dat, 32'h0);

        // byte store to top lane, then signed/unsigned byte loads
        run(LSU_SB, 32'h103, 32'h000000A5);
        chk("sb_dat", f_dat, 32'hA5A5A5A5);
        chk("sb_sel", f_sel, 32'h8);
        chk("sb_adr", f_adr, 32'h100);
        run(LSU_LB, 32'h103, 32'h0);
        chk("lb_rdata", r_rdata, 32'hFFFFFFA5);
        chk("lb_sel", f_sel, 32'h8);
        run(LSU_LBU, 32'h103, 32'h0);
        chk("lbu_rdata", r_rdata, 32'h000000A5);
        run(LSU_LB, 32'h101, 32'h0);
        chk("lb1_rdata", r_rdata, 32'hFFFFFFBE);

        // halfword lanes
        run(LSU_SW, 32'h100, 32'h80011234);
        run(LSU_LH, 32'h102, 32'h0);
        chk("lh_rdata", r_rdata, 32'hFFFF8001);
        run(LSU_LHU, 32'h102, 32'h0);
        chk("lhu_rdata", r_rdata, 32'h00008001);
        run(LSU_LH, 32'h100, 32'h0);
        chk("lh0_rdata", r_rdata, 32'h00001234);
        run(LSU_SH, 32'h102, 32'h1234BEEF);
        chk("sh_dat", f_dat, 32'hBEEFBEEF);
        chk("sh_sel", f_sel, 32'hC);
        run(LSU_LW, 32'h100, 32'h0);
        chk("sh_lw", r_rdata, 32'hBEEF1234);

        // misaligned accesses: no bus cycle, flag at first cycle
        run(LSU_LW, 32'h102, 32'h0);
        chk("mis_lw_lat", r_lat, 32'd1);
        chk("mis_lw_flag", {31'h0, r_mis}, 32'h1);
        chk("mis_lw_cyc", {31'h0, r_cyc_seen}, 32'h0);
        chk("mis_lw_rdata", r_rdata, 32'h0);
        run(LSU_SH, 32'h101, 32'h0);
        chk("mis_sh_flag", {31'h0, r_mis}, 32'h1);
        chk("mis_sh_cyc", {31'h0, r_cyc_seen}, 32'h0);
        run(LSU_LB, 32'h103, 32'h0);
        chk("aligned_mis", {31'h0, r_mis}, 32'h0);

        // five wait cycles with stall asserted
        wait_n = 5;
        run(LSU_SW, 32'h104, 32'h0BADF00D);
        chk("wait_stable", {31'h0, r_unstable}, 32'h0);
        chk("wait_lat", r_lat, 32'd8);
        chk("wait_ack_to_rsp", r_lat - r_ack_lat, 32'd1);
        chk("wait_single", {31'h0, r_extra}, 32'h0);
        run(LSU_LW, 32'h104, 32'h0);
        chk("wait_lw", r_rdata, 32'h0BADF00D);
        wait_n = 0;

        // err together with ack
        inj_err = 1'b1;
        run(LSU_LW, 32'h104, 32'h0);
        chk("err_flag", {31'h0, r_err}, 32'h1);
        chk("err_rdata", r_rdata, 32'h0);
        inj_err = 1'b0;

        // reset while in BUS
        no_ack = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b1; req_op_i = LSU_LW; req_addr_i = 32'h100;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        @(posedge clk_i);
        #2;
        chk("rstbus_cyc_before", {31'h0, wb_cyc_o}, 32'h1);
        rst_ni = 1'b0;
        #1;
        chk("rstbus_cyc", {31'h0, wb_cyc_o}, 32'h0);
        chk("rstbus_stb", {31'h0, wb_stb_o}, 32'h0);
        no_ack = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i);
            #1;
            if (rsp_valid_o) cnt++;
        end
        chk("rstbus_no_rsp", cnt, 32'd0);
        chk("rstbus_ready", {31'h0, req_ready_o}, 32'h1);

`ifdef RV32I_LSU_TIMEOUT_EN
        no_ack = 1'b1;
        run(LSU_LW, 32'h100, 32'h0);
        chk("tmo_lat", r_lat, 32'd10);
        chk("tmo_err", {31'h0, r_err}, 32'h1);
        chk("tmo_cyc_after", {31'h0, wb_cyc_o}, 32'h0);
        no_ack = 1'b0;
`endif

        // unit still usable afterwards
        run(LSU_LW, 32'h104, 32'h0);
        chk("final_lw", r_rdata, 32'h0BADF00D);
        chk("final_lat", r_lat, 32'd3);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
